// File: rtl/water_raid_pkg.sv
// water_raid_pkg: shared geometry, boundary widths and reader states for the river renderer.
package water_raid_pkg;
   localparam int POS_W = 10;
   localparam int ADDR_W = 8;
   localparam int ROW_SHIFT = 1;
   localparam logic [POS_W-1:0] CENTER = 10'd320;
   localparam logic [POS_W-1:0] TWO_CENTER = CENTER + CENTER;
   localparam logic [10:0] H_ACTIVE = 11'd640;
   localparam logic [10:0] H_TOTAL = 11'd800;
   localparam logic [9:0] V_TOTAL = 10'd525;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, CAP, DONE} reader_state_t;
   // Row of the line after v; the last line of the frame wraps to row 0.
   function automatic logic [ADDR_W-1:0] row_of(input logic [9:0] v);
      logic [9:0] n;
      n = (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
      return ADDR_W'(n >> ROW_SHIFT);
   endfunction
endpackage

// File: rtl/edge_compare.sv
// edge_compare: a visible pixel is land when it lies left of the left bank or at/after the right bank.
module edge_compare
   import water_raid_pkg::*;
(
   input  logic [10:0]      hcount,
   input  logic [POS_W-1:0] left,
   input  logic [POS_W-1:0] right,
   output logic             land_d
);
   assign land_d = (hcount < H_ACTIVE) && ((hcount < 11'(left)) || (hcount >= 11'(right)));
endmodule

// File: rtl/boundary_scan_reader.sv
// boundary_scan_reader: fetches next line's left bank during h-blank, mirrors the right bank,
// commits both at line end and flags each visible pixel as land or water.
module boundary_scan_reader
   import water_raid_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   output logic [ADDR_W-1:0] address,
   output logic              selectSignal,
   input  logic [POS_W-1:0]  boundaryOutput,
   input  logic              shiftSignal,
   output logic [POS_W-1:0]  left_edge,
   output logic [POS_W-1:0]  right_edge,
   output logic              land,
   output logic              stale
);
   reader_state_t state, state_n;
   logic shift_seen, commit, retry, land_d;
   logic [POS_W-1:0] shadow_left, shadow_right, clamped;
   assign commit = hcount == H_TOTAL - 11'd1;
   assign clamped = (boundaryOutput > CENTER) ? CENTER : boundaryOutput;
   assign retry = shift_seen || shiftSignal;
   edge_compare u_cmp (
      .hcount(hcount),
      .left  (left_edge),
      .right (right_edge),
      .land_d(land_d)
   );
   always_comb begin
      state_n = state;
      selectSignal = state == REQ;
      case (state)
         IDLE:    state_n = (hcount == H_ACTIVE) ? REQ : IDLE;
         REQ:     state_n = WAIT;
         WAIT:    state_n = CAP;
         CAP:     state_n = retry ? REQ : DONE;
         DONE:    state_n = DONE;
         default: state_n = IDLE;
      endcase
      if (commit) state_n = IDLE;
   end
   // A capture landing on the commit cycle is dropped; the line then reuses old edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         address <= '0;
         shift_seen <= 1'b0;
         shadow_left <= '0;
         shadow_right <= TWO_CENTER;
         left_edge <= '0;
         right_edge <= TWO_CENTER;
         land <= 1'b0;
         stale <= 1'b0;
      end else begin
         state <= state_n;
         land <= land_d;
         shift_seen <= (state == REQ || state == WAIT) && retry;
         if (state == IDLE && hcount == H_ACTIVE) address <= row_of(vcount);
         if (state == CAP && !retry && !commit) begin
            shadow_left <= clamped;
            shadow_right <= TWO_CENTER - clamped;
         end
         if (commit) begin
            stale <= state != DONE;
            if (state == DONE) begin
               left_edge <= shadow_left;
               right_edge <= shadow_right;
            end
         end
      end
   end
endmodule
